// File: rtl/bus_txn_sequencer.sv
// Upstream sequencer for the multiplexed 8-bit AD bus: accepts one request, opens a
// fixed-length enAD window (address phase then data phase), then returns a response pulse.
module bus_txn_sequencer #(
  parameter int TXN_CYCLES = 13,
  parameter int ADDR_LAST  = 3,
  parameter int RD_SAMPLE  = 9,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clkAD,
  input  logic       resetAD,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       enAD,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic       rsp_valid,
  output logic       rsp_write,
  output logic [7:0] rsp_rdata,
  output logic       busy
);

  // Handshake: a request transfers on a rising clkAD edge where req_valid and req_ready
  // are both high; req_* are sampled only on that edge. rsp_valid is a one-cycle pulse
  // with no backpressure.

  localparam logic [3:0] ADDR_LAST_C = 4'(ADDR_LAST);
  localparam logic [3:0] RD_SAMPLE_C = 4'(RD_SAMPLE);
  localparam logic [3:0] TXN_LAST_C  = 4'(TXN_CYCLES - 1);
  localparam logic [3:0] GAP_LAST_C  = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_d;
  logic [3:0] cyc;
  logic [3:0] gap_cnt;
  logic       en_q;
  logic       wr_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       accept;

  assign accept = req_valid & req_ready;

  // State register; enAD has its own flop so the window edge is glitch-free.
  always_ff @(posedge clkAD or posedge resetAD) begin
    if (resetAD) begin
      state   <= IDLE;
      en_q    <= 1'b0;
      cyc     <= 4'd0;
      gap_cnt <= 4'd0;
    end else begin
      state   <= state_d;
      en_q    <= (state_d == ADDR) || (state_d == DATA);
      if (state == IDLE) begin
        cyc <= 4'd0;
      end else if (en_q) begin
        cyc <= cyc + 4'd1;
      end
      if (state == GAP) begin
        gap_cnt <= gap_cnt + 4'd1;
      end else begin
        gap_cnt <= 4'd0;
      end
    end
  end

  // Request latch and read capture; writes never touch the read-data register.
  always_ff @(posedge clkAD or posedge resetAD) begin
    if (resetAD) begin
      wr_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if ((state == DATA) && !wr_q && (cyc == RD_SAMPLE_C)) begin
        rdata_q <= bus_in;
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept)                 state_d = ADDR;
      ADDR: if (cyc == ADDR_LAST_C)     state_d = DATA;
      DATA: if (cyc == TXN_LAST_C)      state_d = GAP;
      GAP:  if (gap_cnt == GAP_LAST_C)  state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    bus_oe    = 1'b0;
    bus_out   = 8'h00;
    rsp_valid = 1'b0;
    rsp_write = 1'b0;
    case (state)
      IDLE: req_ready = ~resetAD;
      ADDR: begin
        busy    = 1'b1;
        bus_oe  = 1'b1;
        bus_out = addr_q;
      end
      DATA: begin
        busy = 1'b1;
        if (wr_q) begin
          bus_oe  = 1'b1;
          bus_out = wdata_q;
        end
      end
      GAP: begin
        busy      = 1'b1;
        rsp_valid = (gap_cnt == 4'd0);
        rsp_write = (gap_cnt == 4'd0) & wr_q;
      end
      default: ;
    endcase
  end

  assign enAD      = en_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_bus_txn_sequencer.sv
// Bench for bus_txn_sequencer: table of transactions with per-cycle window checks,
// a response scoreboard, plus back-to-back and mid-window reset sequences.
module tb_bus_txn_sequencer;

  localparam int TXN_CYCLES = 13;
  localparam int ADDR_LAST  = 3;
  localparam int RD_SAMPLE  = 9;

  logic       clk;
  logic       resetAD;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       enAD;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in;
  logic       rsp_valid;
  logic       rsp_write;
  logic [7:0] rsp_rdata;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd_bus;
    logic       noise;
    int         abort_at;
    logic [7:0] exp_rdata;
  } txn_t;

  txn_t tv[7];

  bus_txn_sequencer dut (
    .clkAD     (clk),
    .resetAD   (resetAD),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .enAD      (enAD),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .bus_in    (bus_in),
    .rsp_valid (rsp_valid),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!resetAD && rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got write=%0b rdata=0x%0h expected no response at %0t",
                 rsp_write, rsp_rdata, $time);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({rsp_write, rsp_rdata} !== e) begin
          errors++;
          $display("FAIL rsp_data: got write=%0b rdata=0x%0h expected write=%0b rdata=0x%0h",
                   rsp_write, rsp_rdata, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic wait_ready(output logic got);
    got = 1'b0;
    for (int w = 0; w < 40 && !got; w++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_txn(input txn_t t);
    logic got;
    logic [11:0] exp_vec;
    wait_ready(got);
    if (!got) return;
    req_valid = 1'b1;
    req_write = t.wr;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    exp_q.push_back({t.wr, t.exp_rdata});
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = 8'($urandom_range(0, 255));
    req_wdata = 8'($urandom_range(0, 255));
    for (int k = 0; k < TXN_CYCLES; k++) begin
      exp_vec[11] = 1'b1;
      exp_vec[10] = (k <= ADDR_LAST) ? 1'b1 : t.wr;
      exp_vec[9]  = 1'b1;
      exp_vec[8]  = 1'b0;
      exp_vec[7:0] = (k <= ADDR_LAST) ? t.addr : (t.wr ? t.wdata : 8'h00);
      chk($sformatf("window_cyc%0d", k), {20'd0, enAD, bus_oe, busy, req_ready, bus_out},
          {20'd0, exp_vec});
      if (k == RD_SAMPLE)          bus_in = t.rd_bus;
      else if (k == RD_SAMPLE + 1) bus_in = 8'hFF;
      else                         bus_in = 8'($urandom_range(0, 255));
      if (k == t.abort_at) begin
        resetAD = 1'b1;
        #1;
        chk("abort_outputs", {20'd0, enAD, bus_oe, busy, rsp_valid, bus_out}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        resetAD = 1'b0;
        return;
      end
      if (t.noise) begin
        req_valid = (k == TXN_CYCLES - 1) ? 1'b0 : 1'($urandom_range(0, 1));
        req_addr  = 8'($urandom_range(0, 255));
        req_wdata = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
    end
    chk("gap_first", {28'd0, enAD, bus_oe, busy, rsp_valid}, 32'b0011);
    @(negedge clk);
    chk("gap_second", {28'd0, enAD, bus_oe, busy, rsp_valid}, 32'b0010);
    chk("rdata_hold", {24'd0, rsp_rdata}, {24'd0, t.exp_rdata});
  endtask

  task automatic back_to_back();
    logic got;
    int   n_acc;
    int   last_acc;
    int   hi_run;
    int   lo_run;
    logic prev_en;
    logic seen_hi;
    n_acc = 0; last_acc = 0; hi_run = 0; lo_run = 0; prev_en = 1'b0; seen_hi = 1'b0;
    wait_ready(got);
    if (!got) return;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h20;
    req_wdata = 8'h21;
    for (int n = 0; n <= 60; n++) begin
      if (n > 0) @(negedge clk);
      if (req_valid && req_ready) begin
        exp_q.push_back({1'b1, 8'h96});
        if (n_acc > 0) chk("accept_spacing", n - last_acc, 32'd16);
        last_acc = n;
        n_acc++;
      end
      if (enAD) begin
        if (!prev_en && seen_hi) chk("enad_low_run", lo_run, 32'd3);
        if (!prev_en) hi_run = 0;
        hi_run++;
        seen_hi = 1'b1;
      end else begin
        if (prev_en) begin
          chk("enad_high_run", hi_run, TXN_CYCLES);
          lo_run = 0;
        end
        lo_run++;
      end
      prev_en = enAD;
      if (n == 40) req_valid = 1'b0;
    end
    chk("accept_count", n_acc, 32'd3);
  endtask

  initial begin
    resetAD   = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    bus_in    = 8'h00;

    tv[0] = '{1'b1, 8'h0A, 8'h5C, 8'h00, 1'b0, -1, 8'h00};
    tv[1] = '{1'b0, 8'h0C, 8'h00, 8'hA7, 1'b0, -1, 8'hA7};
    tv[2] = '{1'b1, 8'h55, 8'h3C, 8'h12, 1'b1, -1, 8'hA7};
    tv[3] = '{1'b0, 8'h33, 8'h00, 8'h33, 1'b0, -1, 8'h33};
    tv[4] = '{1'b1, 8'h44, 8'h44, 8'hEE, 1'b1, -1, 8'h33};
    tv[5] = '{1'b1, 8'h77, 8'h88, 8'h00, 1'b0,  6, 8'h00};
    tv[6] = '{1'b0, 8'h5A, 8'h00, 8'h96, 1'b0, -1, 8'h96};

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {12'd0, enAD, bus_oe, busy, req_ready, rsp_valid, rsp_write, rsp_rdata, bus_out}, 32'd0);
    resetAD = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      do_txn(tv[i]);
      if (tv[i].abort_at >= 0) begin
        repeat (20) @(negedge clk);
        chk("abort_rdata_reset", {24'd0, rsp_rdata}, 32'd0);
      end
    end

    back_to_back();

    repeat (30) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("final_rdata", {24'd0, rsp_rdata}, 32'h96);
    chk("final_idle", {29'd0, enAD, busy, req_ready}, 32'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
